// File: rtl/imem_loader_pkg.sv
// Shared configuration and types for the instruction-memory loader.
package imem_loader_pkg;

    // Instruction word width
    localparam int unsigned INST_WIDTH       = 32;

    // Header is a little-endian 32-bit word count
    localparam int unsigned LOADER_HDR_BYTES = 4;

    // Bytes assembled per instruction word
    localparam int unsigned BYTES_PER_WORD   = INST_WIDTH / 8;

    // Loader control states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream little-endian into INST_WIDTH words.
// The completed word and its valid flag are combinational on the cycle the
// last byte is accepted, so the caller can register them directly.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_clr,
    input  logic                  i_byte_en,
    input  logic [7:0]            i_byte,
    output logic [INST_WIDTH-1:0] o_word_c,
    output logic                  o_word_valid_c
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned ACC_W = INST_WIDTH - 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] r_idx;
    logic [ACC_W-1:0] r_acc;

    // Byte index and right-shifting accumulator; earliest byte ends in the low lane
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_byte_en) begin
            if (r_idx == LAST_IDX) begin
                r_idx <= '0;
            end else begin
                r_acc <= {i_byte, r_acc[ACC_W-1:8]};
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign o_word_c       = {i_byte, r_acc};
    assign o_word_valid_c = i_byte_en && (r_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a header word count N followed by N
// little-endian words from a byte stream and writes them from address 0,
// holding the core in reset until the load completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 1024,
    parameter int unsigned BOOT_HOLD = 1,
    localparam int unsigned AW       = $clog2(MEM_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  mem_we_o,
    output logic [AW+1:0]         mem_addr_o,
    output logic [INST_WIDTH-1:0] mem_wdata_o,
    output logic                  cpu_rst_no,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [AW:0]           words_loaded_o
);

    localparam int unsigned HDR_W = LOADER_HDR_BYTES * 8;

    loader_state_e         r_state;
    logic                  r_rx_ready;
    logic                  r_mem_we;
    logic [AW+1:0]         r_mem_addr;
    logic [INST_WIDTH-1:0] r_mem_wdata;
    logic                  r_cpu_rst_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [AW:0]           r_words;
    logic [AW:0]           r_count;

    logic                  w_accept;
    logic                  w_pack_clr;
    logic [INST_WIDTH-1:0] w_word;
    logic                  w_word_valid;
    logic [HDR_W-1:0]      w_hdr_count;
    logic [AW:0]           w_words_next;
    logic                  w_idle_like;

    assign w_idle_like  = (r_state != ST_HDR) && (r_state != ST_LOAD);
    assign w_accept     = rx_valid_i && r_rx_ready;
    assign w_pack_clr   = w_idle_like && start_i;
    assign w_hdr_count  = HDR_W'(w_word);
    assign w_words_next = r_words + (AW+1)'(1);

    byte_packer u_packer (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .i_clr          (w_pack_clr),
        .i_byte_en      (w_accept),
        .i_byte         (rx_data_i),
        .o_word_c       (w_word),
        .o_word_valid_c (w_word_valid)
    );

    // Load sequencer with registered handshake, write port and status outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst_n <= (BOOT_HOLD == 0);
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
            r_count     <= '0;
        end else begin
            r_mem_we <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        r_state     <= ST_HDR;
                        r_rx_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_words     <= '0;
                        r_cpu_rst_n <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (abort_i) begin
                        r_state    <= ST_ERR;
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                    end else if (w_word_valid) begin
                        if (w_hdr_count == '0) begin
                            r_state     <= ST_DONE;
                            r_rx_ready  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
                        end else if (w_hdr_count > HDR_W'(MEM_SIZE)) begin
                            r_state    <= ST_ERR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                            r_count <= (AW+1)'(w_hdr_count);
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort_i) begin
                        // Any partially assembled word is dropped
                        r_state    <= ST_ERR;
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                    end else if (w_word_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_word;
                        r_mem_addr  <= {r_words[AW-1:0], 2'b00};
                        r_words     <= w_words_next;
                        if (w_words_next == r_count) begin
                            r_state     <= ST_DONE;
                            r_rx_ready  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready_o     = r_rx_ready;
    assign mem_we_o       = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;
    assign cpu_rst_no     = r_cpu_rst_n;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign words_loaded_o = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default MEM_SIZE=1024, BOOT_HOLD=1).
module tb_imem_loader;

    localparam int unsigned AW = 10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        mem_we_o;
    logic [AW+1:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_rst_no;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [AW:0] words_loaded_o;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];
    logic        wr_done [0:15];
    int          wr_count = 0;

    imem_loader dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_ready_o     (rx_ready_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .cpu_rst_no     (cpu_rst_no),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every cycle with the write strobe high (sampled mid-cycle)
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            if (wr_count < 16) begin
                wr_addr[wr_count] = 32'(mem_addr_o);
                wr_data[wr_count] = mem_wdata_o;
                wr_done[wr_count] = done_o;
            end
            wr_count = wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk_i);
            rx_valid_i = 1'b0;
        end
        @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        t = 0;
        while (!rx_ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 20) check("byte_accept_timeout", 32'(t), 32'd0);
    endtask

    task automatic end_stream();
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] v;
        v = w;
        for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], gap);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        // Reset state with BOOT_HOLD=1
        wait_cycles(3);
        rst_ni = 1'b1;
        wait_cycles(2);
        check("rst_cpu_rst_n", 32'(cpu_rst_no), 32'd0);
        check("rst_rx_ready",  32'(rx_ready_o), 32'd0);
        check("rst_busy",      32'(busy_o), 32'd0);
        check("rst_done",      32'(done_o), 32'd0);
        check("rst_err",       32'(err_o), 32'd0);
        check("rst_we",        32'(mem_we_o), 32'd0);
        check("rst_words",     32'(words_loaded_o), 32'd0);
        check("rst_addr",      32'(mem_addr_o), 32'd0);

        // Two-word load, back-to-back bytes
        wr_count = 0;
        pulse_start();
        check("hdr_busy",     32'(busy_o), 32'd1);
        check("hdr_rx_ready", 32'(rx_ready_o), 32'd1);
        send_word(32'h0000_0002, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        end_stream();
        wait_cycles(3);
        check("ld_wr_count", 32'(wr_count), 32'd2);
        check("ld_addr0",    wr_addr[0], 32'h0);
        check("ld_data0",    wr_data[0], 32'h0000_0013);
        check("ld_addr1",    wr_addr[1], 32'h4);
        check("ld_data1",    wr_data[1], 32'h0010_0093);
        check("ld_done_at_w0", 32'(wr_done[0]), 32'd0);
        check("ld_done_at_w1", 32'(wr_done[1]), 32'd1);
        check("ld_done",     32'(done_o), 32'd1);
        check("ld_cpu_rst_n",32'(cpu_rst_no), 32'd1);
        check("ld_words",    32'(words_loaded_o), 32'd2);
        check("ld_busy",     32'(busy_o), 32'd0);
        check("ld_rx_ready", 32'(rx_ready_o), 32'd0);

        // Same load with valid gaps; nothing written while word 1 is partial
        wr_count = 0;
        pulse_start();
        check("gap_done_cleared", 32'(done_o), 32'd0);
        check("gap_cpu_held",     32'(cpu_rst_no), 32'd0);
        send_word(32'h0000_0002, $urandom_range(0, 5));
        send_word(32'h0000_0013, $urandom_range(0, 5));
        send_byte(8'h93, $urandom_range(0, 5));
        send_byte(8'h00, $urandom_range(0, 5));
        send_byte(8'h10, $urandom_range(0, 5));
        end_stream();
        wait_cycles(5);
        check("gap_partial_no_write", 32'(wr_count), 32'd1);
        check("gap_partial_words",    32'(words_loaded_o), 32'd1);
        send_byte(8'h00, 3);
        end_stream();
        wait_cycles(3);
        check("gap_wr_count", 32'(wr_count), 32'd2);
        check("gap_addr0",    wr_addr[0], 32'h0);
        check("gap_data0",    wr_data[0], 32'h0000_0013);
        check("gap_addr1",    wr_addr[1], 32'h4);
        check("gap_data1",    wr_data[1], 32'h0010_0093);
        check("gap_done",     32'(done_o), 32'd1);
        check("gap_words",    32'(words_loaded_o), 32'd2);

        // Oversized header: N = MEM_SIZE + 1
        wr_count = 0;
        pulse_start();
        send_word(32'h0000_0401, 0);
        end_stream();
        wait_cycles(3);
        check("ovf_err",      32'(err_o), 32'd1);
        check("ovf_done",     32'(done_o), 32'd0);
        check("ovf_writes",   32'(wr_count), 32'd0);
        check("ovf_cpu_rst_n",32'(cpu_rst_no), 32'd0);
        check("ovf_busy",     32'(busy_o), 32'd0);
        check("ovf_rx_ready", 32'(rx_ready_o), 32'd0);

        // Header N = MEM_SIZE is accepted (boundary)
        pulse_start();
        send_word(32'h0000_0400, 0);
        end_stream();
        wait_cycles(2);
        check("max_hdr_busy", 32'(busy_o), 32'd1);
        check("max_hdr_err",  32'(err_o), 32'd0);

        // Abort after 6 data bytes of N=3 (restart first; start ignored while busy)
        @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        wr_count = 0;
        pulse_start();
        send_word(32'h0000_0003, 0);
        send_word(32'h4433_2211, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        abort_i    = 1'b1;
        start_i    = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        start_i = 1'b0;
        wait_cycles(3);
        check("abt_writes",   32'(wr_count), 32'd1);
        check("abt_addr0",    wr_addr[0], 32'h0);
        check("abt_data0",    wr_data[0], 32'h4433_2211);
        check("abt_err",      32'(err_o), 32'd1);
        check("abt_words",    32'(words_loaded_o), 32'd1);
        check("abt_cpu_rst_n",32'(cpu_rst_no), 32'd0);
        check("abt_busy",     32'(busy_o), 32'd0);

        // Reset mid-load, then an empty load
        pulse_start();
        send_word(32'h0000_0002, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_byte(8'h77, 0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        rst_ni     = 1'b0;
        wait_cycles(2);
        wr_count = 0;
        check("mrst_cpu_rst_n",32'(cpu_rst_no), 32'd0);
        check("mrst_busy",     32'(busy_o), 32'd0);
        check("mrst_rx_ready", 32'(rx_ready_o), 32'd0);
        check("mrst_words",    32'(words_loaded_o), 32'd0);
        check("mrst_err",      32'(err_o), 32'd0);
        check("mrst_done",     32'(done_o), 32'd0);
        check("mrst_addr",     32'(mem_addr_o), 32'd0);
        check("mrst_wdata",    mem_wdata_o, 32'd0);
        rst_ni = 1'b1;
        wait_cycles(1);
        pulse_start();
        send_word(32'h0000_0000, 0);
        end_stream();
        wait_cycles(3);
        check("empty_done",     32'(done_o), 32'd1);
        check("empty_cpu_rst_n",32'(cpu_rst_no), 32'd1);
        check("empty_writes",   32'(wr_count), 32'd0);
        check("empty_words",    32'(words_loaded_o), 32'd0);
        check("empty_err",      32'(err_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream over valid/ready (from a UART RX or a debug bridge) and assembles little-endian 32-bit instruction words.
- Issues single-cycle word writes into the instruction memory write port, starting at byte address 0.
- Holds the core in reset while a program is being loaded, then releases it.

Parameters:
- MEM_SIZE, 1024, instruction memory depth in words; AW = $clog2(MEM_SIZE).
- BOOT_HOLD, 1, 1: core held in reset from reset until the first successful load; 0: core runs while IDLE.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous, active-low reset
- start_i  in  1  single-cycle pulse; begins a load
- abort_i  in  1  abandons a load in progress
- rx_data_i  in  8  stream byte
- rx_valid_i  in  1  byte valid
- rx_ready_o  out  1  byte accepted when rx_valid_i && rx_ready_o
- mem_we_o  out  1  word write strobe
- mem_addr_o  out  AW+2  byte address, word aligned (bits [1:0] = 0)
- mem_wdata_o  out  INST_WIDTH  word to write
- cpu_rst_no  out  1  active-low core reset
- busy_o  out  1  in HDR or LOAD
- done_o  out  1  last load completed
- err_o  out  1  last load failed
- words_loaded_o  out  AW+1  words written in the current or last load

Behaviour:
- Synchronous, active-low reset; all state updates on rising clk_i.
- Reset values:
  - state = IDLE.
  - rx_ready_o, mem_we_o, busy_o, done_o, err_o = 0.
  - mem_addr_o, mem_wdata_o, words_loaded_o = 0.
  - cpu_rst_no = !BOOT_HOLD.
- States: IDLE, HDR, LOAD, DONE, ERR.
- IDLE / DONE / ERR:
  - rx_ready_o = 0.
  - start_i -> HDR. On entry: clear byte index, word count, words_loaded_o, done_o and err_o; drive cpu_rst_no = 0.
- HDR:
  - rx_ready_o = 1. Accept 4 bytes as a little-endian 32-bit count N.
  - On the 4th accepted byte:
    - N == 0 -> DONE.
    - N > MEM_SIZE -> ERR.
    - Otherwise -> LOAD.
- LOAD:
  - rx_ready_o = 1 continuously. Bytes are packed little-endian: byte k goes to bits [8k+7:8k].
  - On acceptance of the 4th byte of word i (cycle t):
    - mem_wdata_o is registered with the assembled word.
    - mem_addr_o = 4*i.
    - mem_we_o = 1 for exactly cycle t+1.
    - words_loaded_o increments at t+1.
  - A byte accepted at t+1 goes into the next word; no bubble is required.
  - When word N-1 is written, DONE is entered at t+1, concurrent with the final write strobe.
- DONE: done_o = 1, cpu_rst_no = 1, busy_o = 0.
- ERR: err_o = 1, cpu_rst_no stays 0, busy_o = 0.
- abort_i in HDR or LOAD -> ERR next cycle.
  - A partial word is discarded, with no write.
  - A write strobe already scheduled for that cycle still completes.
- start_i during HDR or LOAD is ignored.
- abort_i and start_i asserted together: abort wins in HDR/LOAD; start wins in IDLE/DONE/ERR.
- A gap in rx_valid_i is legal anywhere; the byte index holds.
- mem_we_o is never asserted outside LOAD and the LOAD->DONE transition cycle.
- Reset asserted mid-load: immediate return to reset values. Memory contents are partially written and are not defined as valid.
- Width rules:
  - Count compare uses 32-bit N against MEM_SIZE; no truncation before the compare.
  - mem_addr_o = {word_idx, 2'b00}.

Decomposition:
- pkg_config: INST_WIDTH (existing).
- New package items:
  - loader state enum type.
  - LOADER_HDR_BYTES = 4.
  - BYTES_PER_WORD = INST_WIDTH/8.
- Sub-module `byte_packer`: shift/pack of bytes into a word, with a byte index and a word_valid pulse. Natural to split; the FSM stays in imem_loader.

Test Plan:
- BOOT_HOLD=1, reset released, no stimulus -> cpu_rst_no=0, rx_ready_o=0, all flags 0.
- start_i; header 02 00 00 00; bytes 13 00 00 00 93 00 10 00 ->
  - write addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093, each mem_we_o one cycle.
  - done_o=1, cpu_rst_no=1, words_loaded_o=2.
- Same load with random rx_valid_i gaps (0–5 cycles) -> identical writes and data; no write while a partial word is pending.
- Header with N = MEM_SIZE+1 (0x401 for default) -> ERR after the 4th header byte; err_o=1, zero mem_we_o pulses, cpu_rst_no=0.
- abort_i after 6 data bytes of N=3 -> exactly 1 write (addr 0x0); then ERR, words_loaded_o=1.
- rst_ni low mid-LOAD, then start_i with N=0 -> all outputs at reset values; then DONE with zero writes, cpu_rst_no=1.
